best_k_tracker: RTL
===================

# best_k_tracker

Streaming K-best tracker: accepts one (index, value) sample per cycle over a framed stream and keeps a sorted table of the K best samples, ranked by minimum or maximum value. It emits a registered best-update strobe whenever rank 0 changes. At end of frame it drains the ranked results over a valid/ready handshake. It sits between a data-producing datapath and the register-write / result-collection logic as the clocked, parametrised successor of the single-minimum finder.

## Interface
Parameters:
- VAL_W, 9: sample value width, unsigned.
- IDX_W, 16: sample index width.
- K, 4: table depth (ranks 0..K-1), K ≥ 1.
- MODE_MAX, 0: 0 ranks smallest value first; 1 ranks largest value first.
- TIE_LATEST, 1: 1 means a new sample equal to an entry beats it; 0 means the earlier entry is kept ahead.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears the table and opens a frame.
- in_valid  in  1  sample valid.
- in_ready  out  1  high only in ACCUM.
- in_index  in  IDX_W  sample index.
- in_value  in  VAL_W  sample value.
- in_last  in  1  marks the final sample of the frame; qualified by in_valid && in_ready.
- best_update  out  1  one-cycle strobe: rank 0 was replaced.
- best_index  out  IDX_W  rank-0 index.
- best_value  out  VAL_W  rank-0 value.
- res_valid  out  1  result entry valid (DRAIN only).
- res_ready  in  1  consumer accepts the result entry.
- res_rank  out  clog2(K) or 1 if K=1  rank of the presented entry.
- res_index  out  IDX_W  presented entry index.
- res_value  out  VAL_W  presented entry value.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States are IDLE, ACCUM and DRAIN. Reset puts the block in IDLE and zeroes every output, all table entries, all entry-valid bits and count.
- IDLE: in_ready=0 and samples are ignored. start moves the block to ACCUM and clears the table.
- ACCUM: in_ready=1. Each accepted sample is compared against the table entries.
  - A new sample "beats" an invalid entry always.
  - A new sample beats a valid entry when its value is strictly better, or when the values are equal and TIE_LATEST=1.
  - Insert position p is the lowest rank the sample beats. Entries p..K-2 shift down one rank, entry K-1 is dropped, and the sample is written at p.
  - If the sample beats no entry, it is discarded.
  - count increments on insert and saturates at K.
  - If p=0, best_update pulses.
- An accepted sample with in_last moves the block to DRAIN after the sample is inserted. Since in_last marks a real sample, count ≥ 1.
- DRAIN: present entries rank 0..count-1 in order.
  - res_valid=1.
  - The rank advances on res_valid && res_ready.
  - Acceptance of rank count-1 returns the block to IDLE and pulses done.
- start in ACCUM or DRAIN aborts the current frame, clears the table and goes to ACCUM. The draining result is dropped and done is not pulsed.
- Comparisons are unsigned at full VAL_W. There are no arithmetic widths beyond compare.

## Timing
- Table update, best_update, best_index and best_value are all registered on the edge that accepts the sample, so they are visible the next cycle.
- best_update is high for exactly one cycle per rank-0 replacement. Back-to-back winners give back-to-back strobes.
- best_index and best_value hold their value until the next rank-0 replacement, a start, or reset. start clears both to 0.
- DRAIN begins the cycle after the in_last acceptance edge. res_valid is high that cycle with res_rank=0.
- While res_ready=0, res_rank, res_index and res_value are held stable.
- One result is accepted per cycle at most, so drain latency is count cycles with res_ready held high.
- done is asserted the cycle after the final handshake, and the block is in IDLE in that same cycle.
- Asserting Rst_n low at any time clears all state immediately, without waiting for a clock edge. The first edge after release leaves the block in IDLE.
- A start pulse on the same cycle as an in_valid sample: the clear takes priority and the sample is not accepted, because in_ready was 0 in IDLE; in ACCUM the sample is dropped as well.

## Test plan
- Basic ordering (K=4, min, TIE_LATEST=1):
  - Stimulus: values 50, 20, 70, 10, 30 at idx 0..4, in_last on idx 4.
  - Required: best_update after idx 0, 1 and 3. Drain gives (r0: idx 3, 10), (r1: idx 1, 20), (r2: idx 4, 30), (r3: idx 0, 50), then done.
- Ties:
  - Stimulus: 20 at idx 5, then 20 at idx 6 (last).
  - With TIE_LATEST=1: rank 0 is idx 6, rank 1 is idx 5, and best_update fires twice.
  - With TIE_LATEST=0: rank 0 is idx 5 and best_update fires once.
- Short frame:
  - Stimulus: a single sample, value 255 at idx 9, with in_last.
  - Required: exactly one result (rank 0, idx 9, value 255), then done. The block returns to IDLE with in_ready=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 3 DRAIN cycles.
  - Required: res_valid stays high and the rank 0 outputs stay stable. Releasing res_ready advances to rank 1 the next cycle.
- Reset and abort:
  - Reset stimulus: pull Rst_n low after 2 samples in ACCUM.
    - Required: all outputs read 0 immediately and the state is IDLE. in_valid is ignored until the next start.
  - Abort stimulus: pulse start mid-DRAIN.
    - Required: the table clears, the block is in ACCUM, and there is no done pulse.
- Max mode (MODE_MAX=1, K=4, TIE_LATEST=1):
  - Stimulus: 3, 9, 9, 1 at idx 0..3.
  - Required: drain gives (idx 2, 9), (idx 1, 9), (idx 0, 3), (idx 3, 1).

Source files
------------

// File: rtl/best_k_tracker.sv
// best_k_tracker: keeps a sorted table of the K best (index, value) samples of a framed
// stream, strobes on every rank-0 change, and drains the ranked table over valid/ready.
module best_k_tracker #(
    parameter int VAL_W      = 9,
    parameter int IDX_W      = 16,
    parameter int K          = 4,
    parameter int MODE_MAX   = 0,
    parameter int TIE_LATEST = 1,
    localparam int RANK_W    = (K > 1) ? $clog2(K) : 1,
    localparam int CNT_W     = $clog2(K + 1)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [VAL_W-1:0]  in_value,
    input  logic              in_last,
    output logic              best_update,
    output logic [IDX_W-1:0]  best_index,
    output logic [VAL_W-1:0]  best_value,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RANK_W-1:0] res_rank,
    output logic [IDX_W-1:0]  res_index,
    output logic [VAL_W-1:0]  res_value,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  tab_idx_r [K];
    logic [VAL_W-1:0]  tab_val_r [K];
    logic [K-1:0]      tab_vld_r;
    logic [CNT_W-1:0]  count_r;

    logic [K-1:0]      beat_s;
    logic              hit_s;
    logic [RANK_W-1:0] pos_s;
    logic [IDX_W-1:0]  nxt_idx_s [K];
    logic [VAL_W-1:0]  nxt_val_s [K];
    logic [K-1:0]      nxt_vld_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [RANK_W-1:0] rank_nxt_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [VAL_W-1:0]  rd_val_s;
    logic              last_s;

    // An invalid slot is always beaten; equal values only win when the later sample is favoured.
    function automatic logic beats(input logic [VAL_W-1:0] new_val,
                                   input logic [VAL_W-1:0] ent_val,
                                   input logic             ent_vld);
        logic b;
        if (!ent_vld) begin
            b = 1'b1;
        end else if (new_val == ent_val) begin
            b = (TIE_LATEST != 0);
        end else if (MODE_MAX != 0) begin
            b = (new_val > ent_val);
        end else begin
            b = (new_val < ent_val);
        end
        return b;
    endfunction

    // Find the lowest rank the incoming sample beats (the insert position).
    always_comb begin
        beat_s = '0;
        pos_s  = '0;
        for (int i = K - 1; i >= 0; i--) begin
            beat_s[i] = beats(in_value, tab_val_r[i], tab_vld_r[i]);
            pos_s     = beat_s[i] ? RANK_W'(i) : pos_s;
        end
    end

    assign hit_s = |beat_s;

    // Table after insertion: ranks above pos kept, sample at pos, the rest shift down one.
    always_comb begin
        nxt_idx_s    = tab_idx_r;
        nxt_val_s    = tab_val_r;
        nxt_vld_s    = tab_vld_r;
        nxt_idx_s[0] = (hit_s && pos_s == '0) ? in_index : tab_idx_r[0];
        nxt_val_s[0] = (hit_s && pos_s == '0) ? in_value : tab_val_r[0];
        nxt_vld_s[0] = tab_vld_r[0] | (hit_s && pos_s == '0);
        for (int i = 1; i < K; i++) begin
            if (!hit_s || int'(pos_s) > i) begin
                nxt_idx_s[i] = tab_idx_r[i];
                nxt_val_s[i] = tab_val_r[i];
                nxt_vld_s[i] = tab_vld_r[i];
            end else if (int'(pos_s) == i) begin
                nxt_idx_s[i] = in_index;
                nxt_val_s[i] = in_value;
                nxt_vld_s[i] = 1'b1;
            end else begin
                nxt_idx_s[i] = tab_idx_r[i-1];
                nxt_val_s[i] = tab_val_r[i-1];
                nxt_vld_s[i] = tab_vld_r[i-1];
            end
        end
        count_nxt_s = (hit_s && count_r != CNT_W'(K)) ? count_r + CNT_W'(1'b1) : count_r;
    end

    // Drain read port: the entry that follows the one currently presented.
    always_comb begin
        rank_nxt_s = res_rank + RANK_W'(1'b1);
        rd_idx_s   = '0;
        rd_val_s   = '0;
        for (int i = 0; i < K; i++) begin
            rd_idx_s = (RANK_W'(i) == rank_nxt_s) ? tab_idx_r[i] : rd_idx_s;
            rd_val_s = (RANK_W'(i) == rank_nxt_s) ? tab_val_r[i] : rd_val_s;
        end
        last_s = ((32'(res_rank) + 32'd1) == 32'(count_r));
    end

    // Control FSM, table storage and all registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            tab_vld_r   <= '0;
            count_r     <= '0;
            in_ready    <= 1'b0;
            best_update <= 1'b0;
            best_index  <= '0;
            best_value  <= '0;
            res_valid   <= 1'b0;
            res_rank    <= '0;
            res_index   <= '0;
            res_value   <= '0;
            done        <= 1'b0;
            for (int i = 0; i < K; i++) begin
                tab_idx_r[i] <= '0;
                tab_val_r[i] <= '0;
            end
        end else begin
            best_update <= 1'b0;
            done        <= 1'b0;
            if (start) begin
                // start wins over any sample or handshake in the same cycle
                state_r    <= ST_ACCUM;
                in_ready   <= 1'b1;
                tab_vld_r  <= '0;
                count_r    <= '0;
                best_index <= '0;
                best_value <= '0;
                res_valid  <= 1'b0;
                res_rank   <= '0;
                res_index  <= '0;
                res_value  <= '0;
                for (int i = 0; i < K; i++) begin
                    tab_idx_r[i] <= '0;
                    tab_val_r[i] <= '0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        in_ready  <= 1'b0;
                        res_valid <= 1'b0;
                    end
                    ST_ACCUM: begin
                        if (in_valid) begin
                            tab_idx_r <= nxt_idx_s;
                            tab_val_r <= nxt_val_s;
                            tab_vld_r <= nxt_vld_s;
                            count_r   <= count_nxt_s;
                            if (hit_s && pos_s == '0) begin
                                best_update <= 1'b1;
                                best_index  <= in_index;
                                best_value  <= in_value;
                            end
                            if (in_last) begin
                                state_r   <= ST_DRAIN;
                                in_ready  <= 1'b0;
                                res_valid <= 1'b1;
                                res_rank  <= '0;
                                res_index <= nxt_idx_s[0];
                                res_value <= nxt_val_s[0];
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (res_ready) begin
                            if (last_s) begin
                                state_r   <= ST_IDLE;
                                res_valid <= 1'b0;
                                res_rank  <= '0;
                                res_index <= '0;
                                res_value <= '0;
                                done      <= 1'b1;
                            end else begin
                                res_rank  <= rank_nxt_s;
                                res_index <= rd_idx_s;
                                res_value <= rd_val_s;
                            end
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        in_ready  <= 1'b0;
                        res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
